gpio_intr_ctrl: RTL and testbench



---
 rtl/gpio_intr_pkg.sv | 25 ++
 rtl/gpio_intr_pin.sv | 72 +++++++
 rtl/gpio_intr_ctrl.sv | 127 ++++++++++++
 tb/tb_gpio_intr_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_intr_pkg.sv
// rtl/gpio_intr_pkg.sv - shared mode type, register map and bus width for gpio_intr_ctrl
package gpio_intr_pkg;

    localparam int BUS_DATA_WIDTH = 32;
    localparam int BUS_ADDR_WIDTH = 5;

    typedef enum logic [1:0] {
        MODE_OFF  = 2'd0,
        MODE_RISE = 2'd1,
        MODE_FALL = 2'd2,
        MODE_BOTH = 2'd3
    } gpio_mode_e;

    localparam logic [BUS_ADDR_WIDTH-1:0] ADDR_VALUE   = 5'h00;
    localparam logic [BUS_ADDR_WIDTH-1:0] ADDR_MODE    = 5'h04;
    localparam logic [BUS_ADDR_WIDTH-1:0] ADDR_MASK    = 5'h08;
    localparam logic [BUS_ADDR_WIDTH-1:0] ADDR_PENDING = 5'h0C;
    localparam logic [BUS_ADDR_WIDTH-1:0] ADDR_STATUS  = 5'h10;

    function automatic logic mode_match(input gpio_mode_e mode, input logic rise, input logic fall);
        return (rise && (mode == MODE_RISE || mode == MODE_BOTH)) ||
               (fall && (mode == MODE_FALL || mode == MODE_BOTH));
    endfunction

endpackage

// File: rtl/gpio_intr_pin.sv
// rtl/gpio_intr_pin.sv - per-pin synchroniser, optional debouncer (GPIO_INTR_DEBOUNCE_EN), edge detect and mode match
module gpio_intr_pin
    import gpio_intr_pkg::*;
#(
    parameter int SYNC_STAGES = 2
`ifdef GPIO_INTR_DEBOUNCE_EN
    ,
    parameter int DEBOUNCE_CYCLES = 16
`endif
) (
    input  logic       clk,    // rising-edge clock
    input  logic       rst_n,  // async active-low reset
    input  logic       pin,    // asynchronous pin input
    input  gpio_mode_e mode,   // edge selection for this pin
    output logic       level,  // synchronised (post-debounce) level
    output logic       hit     // edge matching mode, one cycle wide
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_level;
    logic                   delay_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
        end
    end

    assign sync_level = sync_q[SYNC_STAGES-1];

`ifdef GPIO_INTR_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;
    logic             db_q;

    // Counts consecutive cycles where the synchronised input disagrees with
    // the debounced output; any agreement (a bounce back) restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            db_q  <= 1'b0;
        end else if (sync_level == db_q) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            db_q  <= sync_level;
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign level = db_q;
`else
    assign level = sync_level;
`endif

    // Delay flop resets to 0, so a pin held high through reset shows up as a
    // rising edge once it has propagated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            delay_q <= 1'b0;
        end else begin
            delay_q <= level;
        end
    end

    assign hit = mode_match(mode, level & ~delay_q, ~level & delay_q);

endmodule

// File: rtl/gpio_intr_ctrl.sv
// rtl/gpio_intr_ctrl.sv - GPIO edge interrupt controller with register bus; debounce optional via GPIO_INTR_DEBOUNCE_EN
module gpio_intr_ctrl
    import gpio_intr_pkg::*;
#(
    parameter int DATA_WIDTH      = 12,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                      io_clock,      // clock, rising edge
    input  logic                      io_rst_n,      // async active-low reset
    input  logic [DATA_WIDTH-1:0]     io_gpio,       // asynchronous pin inputs
    input  logic                      io_bus_valid,  // register access request
    output logic                      io_bus_ready,  // always accepts
    input  logic                      io_bus_write,  // 1 = write, 0 = read
    input  logic [BUS_ADDR_WIDTH-1:0] io_bus_addr,   // byte address
    input  logic [BUS_DATA_WIDTH-1:0] io_bus_wdata,  // write data
    output logic [BUS_DATA_WIDTH-1:0] io_bus_rdata,  // read data, holds last value
    output logic                      io_bus_rvalid, // read data valid
    output logic                      io_irq         // level interrupt
);

    localparam int MODE_WIDTH = 2 * DATA_WIDTH;

    if (DATA_WIDTH < 1 || DATA_WIDTH > 16 || SYNC_STAGES < 2 || SYNC_STAGES > 4 ||
        DEBOUNCE_CYCLES < 1) begin : g_param_check
        $error("gpio_intr_ctrl: parameter out of range");
    end

    logic [MODE_WIDTH-1:0]     mode_q;
    logic [DATA_WIDTH-1:0]     mask_q;
    logic [DATA_WIDTH-1:0]     pending_q;
    logic [DATA_WIDTH-1:0]     pending_d;
    logic [DATA_WIDTH-1:0]     level;
    logic [DATA_WIDTH-1:0]     hit;
    logic [BUS_DATA_WIDTH-1:0] rdata_d;
    logic                      wr_en;
    logic                      rd_en;
    logic                      irq_q;
    logic                      rvalid_q;
    logic [BUS_DATA_WIDTH-1:0] rdata_q;

    // Upper write-data bits beyond the implemented fields are intentionally dropped.
    wire unused_wdata = &{1'b0, io_bus_wdata};

    assign wr_en = io_bus_valid & io_bus_write;
    assign rd_en = io_bus_valid & ~io_bus_write;

    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_pin
        gpio_intr_pin #(
            .SYNC_STAGES(SYNC_STAGES)
`ifdef GPIO_INTR_DEBOUNCE_EN
            ,
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`endif
        ) u_pin (
            .clk  (io_clock),
            .rst_n(io_rst_n),
            .pin  (io_gpio[i]),
            .mode (gpio_mode_e'(mode_q[2*i +: 2])),
            .level(level[i]),
            .hit  (hit[i])
        );
    end

    always_ff @(posedge io_clock or negedge io_rst_n) begin
        if (!io_rst_n) begin
            mode_q <= '0;
            mask_q <= '0;
        end else if (wr_en) begin
            if (io_bus_addr == ADDR_MODE) begin
                mode_q <= io_bus_wdata[MODE_WIDTH-1:0];
            end
            if (io_bus_addr == ADDR_MASK) begin
                mask_q <= io_bus_wdata[DATA_WIDTH-1:0];
            end
        end
    end

    // Clear is applied before set so a new edge in the same cycle survives.
    always_comb begin
        pending_d = pending_q;
        if (wr_en && io_bus_addr == ADDR_PENDING) begin
            pending_d = pending_d & ~io_bus_wdata[DATA_WIDTH-1:0];
        end
        pending_d = pending_d | hit;
    end

    always_ff @(posedge io_clock or negedge io_rst_n) begin
        if (!io_rst_n) begin
            pending_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            irq_q     <= |(pending_q & mask_q);
        end
    end

    always_comb begin
        rdata_d = '0;
        case (io_bus_addr)
            ADDR_VALUE:   rdata_d = BUS_DATA_WIDTH'(level);
            ADDR_MODE:    rdata_d = BUS_DATA_WIDTH'(mode_q);
            ADDR_MASK:    rdata_d = BUS_DATA_WIDTH'(mask_q);
            ADDR_PENDING: rdata_d = BUS_DATA_WIDTH'(pending_q);
            ADDR_STATUS:  rdata_d = BUS_DATA_WIDTH'(pending_q & mask_q);
            default:      rdata_d = '0;
        endcase
    end

    always_ff @(posedge io_clock or negedge io_rst_n) begin
        if (!io_rst_n) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= rd_en;
            if (rd_en) begin
                rdata_q <= rdata_d;
            end
        end
    end

    assign io_bus_ready  = 1'b1;
    assign io_bus_rvalid = rvalid_q;
    assign io_bus_rdata  = rdata_q;
    assign io_irq        = irq_q;

endmodule

// File: tb/tb_gpio_intr_ctrl.sv
// tb/tb_gpio_intr_ctrl.sv - directed self-checking bench for gpio_intr_ctrl
module tb_gpio_intr_ctrl;
    import gpio_intr_pkg::*;

    localparam int DW = 12;
    localparam int SS = 2;
    localparam int DB = 16;
`ifdef GPIO_INTR_DEBOUNCE_EN
    localparam int LAT = SS + DB + 1;
`else
    localparam int LAT = SS + 1;
`endif

    logic          io_clock = 1'b0;
    logic          io_rst_n;
    logic [DW-1:0] io_gpio;
    logic          io_bus_valid;
    logic          io_bus_ready;
    logic          io_bus_write;
    logic [4:0]    io_bus_addr;
    logic [31:0]   io_bus_wdata;
    logic [31:0]   io_bus_rdata;
    logic          io_bus_rvalid;
    logic          io_irq;

    int checks   = 0;
    int failures = 0;

    logic [31:0] d;

    gpio_intr_ctrl #(
        .DATA_WIDTH(DW),
        .SYNC_STAGES(SS),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .io_clock     (io_clock),
        .io_rst_n     (io_rst_n),
        .io_gpio      (io_gpio),
        .io_bus_valid (io_bus_valid),
        .io_bus_ready (io_bus_ready),
        .io_bus_write (io_bus_write),
        .io_bus_addr  (io_bus_addr),
        .io_bus_wdata (io_bus_wdata),
        .io_bus_rdata (io_bus_rdata),
        .io_bus_rvalid(io_bus_rvalid),
        .io_irq       (io_irq)
    );

    always #5 io_clock = ~io_clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge io_clock);
        #1;
    endtask

    task automatic bus_write(input logic [4:0] addr, input logic [31:0] data);
        io_bus_valid = 1'b1;
        io_bus_write = 1'b1;
        io_bus_addr  = addr;
        io_bus_wdata = data;
        tick(1);
        io_bus_valid = 1'b0;
        io_bus_write = 1'b0;
    endtask

    task automatic bus_read(input logic [4:0] addr, output logic [31:0] data);
        io_bus_valid = 1'b1;
        io_bus_write = 1'b0;
        io_bus_addr  = addr;
        tick(1);
        io_bus_valid = 1'b0;
        check("rvalid", 32'(io_bus_rvalid), 32'd1);
        data = io_bus_rdata;
    endtask

    initial begin
        io_rst_n     = 1'b0;
        io_gpio      = '0;
        io_bus_valid = 1'b0;
        io_bus_write = 1'b0;
        io_bus_addr  = '0;
        io_bus_wdata = '0;
        tick(2);
        check("rst_irq", 32'(io_irq), 32'd0);
        check("rst_rvalid", 32'(io_bus_rvalid), 32'd0);
        check("rst_rdata", io_bus_rdata, 32'd0);
        check("ready", 32'(io_bus_ready), 32'd1);
        io_rst_n = 1'b1;
        tick(1);
        bus_read(ADDR_MODE, d);    check("rst_mode", d, 32'd0);
        bus_read(ADDR_MASK, d);    check("rst_mask", d, 32'd0);
        bus_read(ADDR_PENDING, d); check("rst_pending", d, 32'd0);

        // pin3 rising edge, enabled
        bus_write(ADDR_MODE, 32'h0000_0040);
        bus_write(ADDR_MASK, 32'h0000_0008);
        io_gpio[3] = 1'b1;
        tick(LAT - 1);
        bus_read(ADDR_PENDING, d);
        check("s1_pend_early", d, 32'd0);
        check("s1_irq_early", 32'(io_irq), 32'd0);
        bus_read(ADDR_PENDING, d);
        check("s1_pend_set", d, 32'h008);
        check("s1_irq_set", 32'(io_irq), 32'd1);
        bus_read(ADDR_STATUS, d);  check("s1_status", d, 32'h008);
        bus_write(ADDR_PENDING, 32'h008);
        check("s1_irq_hold", 32'(io_irq), 32'd1);
        tick(1);
        check("s1_irq_clr", 32'(io_irq), 32'd0);
        bus_read(ADDR_PENDING, d); check("s1_pend_clr", d, 32'd0);
        io_gpio[3] = 1'b0;
        tick(LAT + 2);
        bus_read(ADDR_PENDING, d); check("s1_fall_ignored", d, 32'd0);

        // pin0 both edges, masked off
        bus_write(ADDR_MODE, 32'h0000_0003);
        bus_write(ADDR_MASK, 32'h0000_0000);
        io_gpio[0] = 1'b1;
        tick(20);
        io_gpio[0] = 1'b0;
        tick(LAT + 2);
        bus_read(ADDR_PENDING, d); check("s2_pend", d, 32'h001);
        check("s2_irq_masked", 32'(io_irq), 32'd0);
        bus_write(ADDR_MASK, 32'h0000_0001);
        check("s2_irq_before", 32'(io_irq), 32'd0);
        tick(1);
        check("s2_irq_unmasked", 32'(io_irq), 32'd1);
        bus_write(ADDR_PENDING, 32'h001);
        bus_write(ADDR_MASK, 32'h0);

        // field widths and mode change without edges
        bus_write(ADDR_MODE, 32'hFFFF_FFFF);
        bus_read(ADDR_MODE, d);    check("mode_width", d, 32'h00FF_FFFF);
        bus_read(ADDR_PENDING, d); check("mode_no_edge", d, 32'd0);
        bus_write(ADDR_MASK, 32'hFFFF_FFFF);
        bus_read(ADDR_MASK, d);    check("mask_width", d, 32'h0000_0FFF);
        bus_write(ADDR_MODE, 32'h0);
        bus_write(ADDR_MASK, 32'h0);

        // VALUE register, no modes enabled
        io_gpio = 12'hA5A;
        tick(LAT + 1);
        bus_read(ADDR_VALUE, d);   check("value", d, 32'h0000_0A5A);
        bus_read(ADDR_PENDING, d); check("value_no_pend", d, 32'd0);
        io_gpio = '0;
        tick(LAT + 1);

        // pin5 falling edge coinciding with W1C of bit5
        bus_write(ADDR_MODE, 32'h0000_0800);
        io_gpio[5] = 1'b1;
        tick(LAT + 2);
        bus_read(ADDR_PENDING, d); check("s3_rise_ignored", d, 32'd0);
        io_gpio[5] = 1'b0;
        tick(LAT - 1);
        bus_write(ADDR_PENDING, 32'h020);
        bus_read(ADDR_PENDING, d); check("s3_set_wins", d, 32'h020);
        bus_write(ADDR_PENDING, 32'h020);
        bus_read(ADDR_PENDING, d); check("s3_w1c", d, 32'd0);

        // unmapped addresses and rdata hold
        bus_write(ADDR_MODE, 32'h0);
        bus_write(ADDR_MASK, 32'h0F0);
        bus_read(ADDR_MASK, d);    check("s4_mask", d, 32'h0F0);
        tick(1);
        check("s4_rvalid_low", 32'(io_bus_rvalid), 32'd0);
        check("s4_rdata_hold", io_bus_rdata, 32'h0F0);
        bus_read(5'h14, d);        check("s4_unmapped_rd", d, 32'd0);
        bus_write(5'h18, 32'hFFFF_FFFF);
        check("s4_wr_no_rvalid", 32'(io_bus_rvalid), 32'd0);
        bus_read(ADDR_MASK, d);    check("s4_mask_kept", d, 32'h0F0);
        bus_read(ADDR_MODE, d);    check("s4_mode_kept", d, 32'd0);
        bus_read(ADDR_PENDING, d); check("s4_pend_kept", d, 32'd0);

        // reset in the middle of a read with all bits pending
        bus_write(ADDR_MODE, 32'h00FF_FFFF);
        bus_write(ADDR_MASK, 32'hFFF);
        io_gpio = 12'hFFF;
        tick(LAT + 2);
        bus_read(ADDR_PENDING, d); check("s5_pend_all", d, 32'hFFF);
        check("s5_irq", 32'(io_irq), 32'd1);
        io_bus_valid = 1'b1;
        io_bus_addr  = ADDR_PENDING;
        #3;
        io_rst_n = 1'b0;
        #1;
        check("s5_rst_irq", 32'(io_irq), 32'd0);
        check("s5_rst_rvalid", 32'(io_bus_rvalid), 32'd0);
        check("s5_rst_rdata", io_bus_rdata, 32'd0);
        tick(1);
        io_bus_valid = 1'b0;
        tick(1);
        check("s5_rst_dropped", 32'(io_bus_rvalid), 32'd0);
        io_rst_n = 1'b1;
        bus_read(ADDR_PENDING, d); check("s5_pend_after", d, 32'd0);
        bus_write(ADDR_MODE, 32'h0000_0010);
        tick(LAT - 2);
        bus_read(ADDR_PENDING, d); check("s5_held_high_rise", d, 32'h004);
        bus_read(ADDR_MASK, d);    check("s5_mask_after", d, 32'd0);
        check("s5_irq_after", 32'(io_irq), 32'd0);

`ifdef GPIO_INTR_DEBOUNCE_EN
        // short glitch is filtered, long pulse is accepted
        io_gpio = '0;
        tick(LAT + 2);
        bus_write(ADDR_PENDING, 32'hFFF);
        bus_write(ADDR_MODE, 32'h0000_0004);
        bus_read(ADDR_PENDING, d); check("db_clear", d, 32'd0);
        io_gpio[1] = 1'b1;
        tick(10);
        io_gpio[1] = 1'b0;
        tick(40);
        bus_read(ADDR_PENDING, d); check("db_glitch", d, 32'd0);
        io_gpio[1] = 1'b1;
        tick(LAT - 1);
        bus_read(ADDR_PENDING, d); check("db_early", d, 32'd0);
        bus_read(ADDR_PENDING, d); check("db_set", d, 32'h002);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
